// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   - opcode constants for the instructions the controller must recognise
//   - state_t: controller FSM states
//   - sb_entry_t: one scoreboard slot {valid, destination register}
//   - decode helpers: which sources an opcode reads, which register it writes
package pipe_hazard_ctrl_pkg;

    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BZ   = 6'h0E;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BR_WAIT,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
    } sb_entry_t;

    // R-type ALU ops occupy the even opcodes 0x00..0x0A, I-type the odd 0x01..0x0B.
    function automatic logic is_rtype(input logic [5:0] op);
        return (op <= 6'h0B) && !op[0];
    endfunction

    function automatic logic is_itype(input logic [5:0] op);
        return (op <= 6'h0B) && op[0];
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BZ) || (op == OP_BEQ) || (op == OP_JR);
    endfunction

    function automatic logic uses_rs(input logic [5:0] op);
        return is_rtype(op) || is_itype(op) || (op == OP_LDW) || (op == OP_STW) ||
               (op == OP_BZ) || (op == OP_BEQ) || (op == OP_JR);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return is_rtype(op) || (op == OP_STW) || (op == OP_BEQ);
    endfunction

    // r0 is hardwired, so a write to it never creates a dependency.
    function automatic sb_entry_t dest_of(input logic [5:0] op,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
        sb_entry_t d;
        d = '0;
        if (is_rtype(op)) begin
            d.addr = rd;
        end else if (is_itype(op) || (op == OP_LDW)) begin
            d.addr = rt;
        end
        d.valid = (d.addr != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Destination scoreboard modelling EX/MEM/WB occupancy.
//   clk, reset      : core clock, synchronous active-low reset
//   issue           : an instruction leaves ID this cycle
//   dest_valid/addr : its destination register (ignored unless issue)
//   rs, rt          : source registers of the instruction in ID
//   use_rs, use_rt  : which of those sources the opcode actually reads
//   hit             : a used, nonzero source matches an in-flight destination
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic       dest_valid,
    input  logic [4:0] dest_addr,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    output logic       hit
);

    localparam int unsigned IW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

    sb_entry_t sb [SB_DEPTH];

    // Slot 0 is EX; every cycle the contents move one stage towards WB.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SB_DEPTH; i++) begin
                sb[IW'(i)] <= '0;
            end
        end else begin
            if (issue && dest_valid) begin
                sb[0] <= '{valid: 1'b1, addr: dest_addr};
            end else begin
                sb[0] <= '0;
            end
            for (int unsigned i = 1; i < SB_DEPTH; i++) begin
                sb[IW'(i)] <= sb[IW'(i - 1)];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (sb[IW'(i)].valid) begin
                if (use_rs && (rs != 5'd0) && (sb[IW'(i)].addr == rs)) hit = 1'b1;
                if (use_rt && (rt != 5'd0) && (sb[IW'(i)].addr == rt)) hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller beside the ID stage.
// Decides each cycle whether the IF/ID instruction issues, stalls on a RAW
// hazard, waits for branch resolution, or drains the pipe after HALT.
//   clk, reset          : core clock, synchronous active-low reset
//   id_inst_valid       : IF/ID holds a real instruction
//   id_opcode           : inst[31:26]
//   id_rs/rt/rd_addr    : inst[25:21] / [20:16] / [15:11]
//   ex_branch_taken     : branch in EX resolved taken (used in BR_WAIT only)
//   stall_if            : hold PC and IF/ID
//   bubble_id_ex        : load a NOP into ID/EX
//   flush_if_id         : invalidate IF/ID at the next edge
//   halted              : sticky, pipeline empty after HALT
//   stall_cnt/flush_cnt : saturating RAW-stall-cycle and taken-flush counts
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_inst_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic             ex_branch_taken,
    output logic             stall_if,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DW = $clog2(SB_DEPTH + 1);

    state_t        state;
    logic [DW-1:0] drain_cnt;
    sb_entry_t     dest;
    logic          sb_hit;
    logic          hazard;
    logic          issue;

    always_comb begin
        dest = dest_of(id_opcode, id_rt_addr, id_rd_addr);
    end

    hazard_scoreboard #(
        .SB_DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue      (issue),
        .dest_valid (dest.valid),
        .dest_addr  (dest.addr),
        .rs         (id_rs_addr),
        .rt         (id_rt_addr),
        .use_rs     (uses_rs(id_opcode)),
        .use_rt     (uses_rt(id_opcode)),
        .hit        (sb_hit)
    );

    assign hazard = id_inst_valid && sb_hit;
    assign issue  = reset && (state == ST_RUN) && id_inst_valid && !sb_hit;

    // Held low through reset so nothing stale reaches IF or ID/EX.
    always_comb begin
        stall_if     = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        if (reset) begin
            unique case (state)
                ST_RUN: begin
                    if (!id_inst_valid) begin
                        bubble_id_ex = 1'b1;
                    end else if (hazard) begin
                        stall_if     = 1'b1;
                        bubble_id_ex = 1'b1;
                    end
                end
                ST_BR_WAIT: begin
                    stall_if     = 1'b1;
                    bubble_id_ex = 1'b1;
                    flush_if_id  = ex_branch_taken;
                end
                default: begin
                    stall_if     = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (hazard && (stall_cnt != '1)) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                    if (issue) begin
                        if (is_branch(id_opcode)) begin
                            state <= ST_BR_WAIT;
                        end else if (id_opcode == OP_HALT) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DW'(SB_DEPTH);
                        end
                    end
                end
                ST_BR_WAIT: begin
                    state <= ST_RUN;
                    if (ex_branch_taken && (flush_cnt != '1)) begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt - DW'(1);
                    // Leaving on the last decrement gives exactly SB_DEPTH drain cycles.
                    if (drain_cnt <= DW'(1)) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int DEPTH   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_inst_valid;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic [4:0]       id_rd_addr;
    logic             ex_branch_taken;
    logic             stall_if;
    logic             bubble_id_ex;
    logic             flush_if_id;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_hazard_ctrl #(
        .SB_DEPTH (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_inst_valid   (id_inst_valid),
        .id_opcode       (id_opcode),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_rd_addr      (id_rd_addr),
        .ex_branch_taken (ex_branch_taken),
        .stall_if        (stall_if),
        .bubble_id_ex    (bubble_id_ex),
        .flush_if_id     (flush_if_id),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each register carries the number of upcoming cycles it
    // stays unreadable; the controller mode is a small integer.
    int busy [32];
    int mode;        // 0 normal, 1 branch resolving, 2 draining, 3 halted
    int drain_left;
    int m_halted;
    int m_stall;
    int m_flush;

    function automatic bit reads_rs(input logic [5:0] op);
        return op inside {[6'h00:6'h0B], 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10};
    endfunction

    function automatic bit reads_rt(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0D, 6'h0F};
    endfunction

    function automatic int writes(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        if (op inside {6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A}) return int'(rd);
        if (op inside {6'h01, 6'h03, 6'h05, 6'h07, 6'h09, 6'h0B, 6'h0C}) return int'(rt);
        return 0;
    endfunction

    task automatic model_reset();
        foreach (busy[r]) busy[r] = 0;
        mode = 0; drain_left = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step(input bit v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input bit tk,
                        input bit rst_n, output bit o_stall, output bit o_flush);
        bit haz, iss;
        int e_stall, e_bubble, e_flush, d;
        reset = rst_n; id_inst_valid = v; id_opcode = op;
        id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd; ex_branch_taken = tk;
        @(negedge clk);
        haz = v && ((reads_rs(op) && rs != 0 && busy[rs] > 0) ||
                    (reads_rt(op) && rt != 0 && busy[rt] > 0));
        iss = 0; e_stall = 0; e_bubble = 0; e_flush = 0;
        if (rst_n) begin
            case (mode)
                0: begin
                    if (!v) e_bubble = 1;
                    else if (haz) begin e_stall = 1; e_bubble = 1; end
                    else iss = 1;
                end
                1: begin e_stall = 1; e_bubble = 1; e_flush = tk; end
                default: begin e_stall = 1; e_bubble = 1; end
            endcase
        end
        check_eq("stall_if", stall_if, e_stall);
        check_eq("bubble_id_ex", bubble_id_ex, e_bubble);
        check_eq("flush_if_id", flush_if_id, e_flush);
        check_eq("halted", halted, m_halted);
        check_eq("stall_cnt", stall_cnt, m_stall);
        check_eq("flush_cnt", flush_cnt, m_flush);
        o_stall = stall_if; o_flush = flush_if_id;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            foreach (busy[r]) if (busy[r] > 0) busy[r]--;
            case (mode)
                0: begin
                    if (haz && m_stall < CNT_MAX) m_stall++;
                    if (iss) begin
                        d = writes(op, rt, rd);
                        if (d != 0) busy[d] = DEPTH;
                        if (op inside {6'h0E, 6'h0F, 6'h10}) mode = 1;
                        else if (op == 6'h11) begin mode = 2; drain_left = DEPTH; end
                    end
                end
                1: begin
                    mode = 0;
                    if (tk && m_flush < CNT_MAX) m_flush++;
                end
                2: begin
                    drain_left--;
                    if (drain_left == 0) begin mode = 3; m_halted = 1; end
                end
                default: ;
            endcase
        end
        #1;
    endtask

    bit s, f;
    int cnt;

    task automatic nop_step(input bit rst_n);
        step(0, 6'h00, 5'd0, 5'd0, 5'd0, 0, rst_n, s, f);
    endtask

    initial begin
        model_reset();
        reset = 0; id_inst_valid = 0; id_opcode = '0;
        id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0; ex_branch_taken = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with a live instruction presented: outputs must stay low.
        step(1, 6'h00, 5'd1, 5'd2, 5'd3, 1, 0, s, f);

        // Back-to-back RAW: add r3<-r1,r2 ; add r4<-r3,r5
        step(1, 6'h00, 5'd1, 5'd2, 5'd3, 0, 1, s, f);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 6'h00, 5'd3, 5'd5, 5'd4, 0, 1, s, f);
            if (!s) break;
            cnt++;
        end
        check_eq("raw_b2b_stalls", cnt, 3);
        check_eq("raw_b2b_stall_cnt", stall_cnt, 3);

        // addi r0 then a reader of r0: no stall.
        nop_step(0);
        step(1, 6'h01, 5'd1, 5'd0, 5'd0, 0, 1, s, f);
        step(1, 6'h00, 5'd0, 5'd0, 5'd6, 0, 1, s, f);
        check_eq("r0_no_stall", s, 0);
        // lw r7 ; 2 NOPs ; sw reading r7: one stall cycle.
        step(1, 6'h0C, 5'd1, 5'd7, 5'd0, 0, 1, s, f);
        nop_step(1);
        nop_step(1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 6'h0D, 5'd2, 5'd7, 5'd0, 0, 1, s, f);
            if (!s) break;
            cnt++;
        end
        check_eq("raw_gap2_stalls", cnt, 1);

        // beq taken: one stall/bubble/flush cycle.
        nop_step(0);
        step(1, 6'h0F, 5'd1, 5'd2, 5'd0, 0, 1, s, f);
        step(1, 6'h00, 5'd4, 5'd5, 5'd6, 1, 1, s, f);
        check_eq("beq_taken_flush", {s, f}, 2'b11);
        check_eq("beq_flush_cnt", flush_cnt, 1);

        // bz not taken: one bubble, then the held instruction issues.
        nop_step(0);
        step(1, 6'h0E, 5'd1, 5'd0, 5'd0, 0, 1, s, f);
        step(1, 6'h00, 5'd4, 5'd5, 5'd6, 0, 1, s, f);
        check_eq("bz_nt_wait", {s, f}, 2'b10);
        step(1, 6'h00, 5'd4, 5'd5, 5'd6, 1, 1, s, f);
        check_eq("bz_nt_issue", {s, f}, 2'b00);
        check_eq("bz_flush_cnt", flush_cnt, 0);

        // HALT: three drain cycles, then sticky halted regardless of inputs.
        nop_step(0);
        step(1, 6'h11, 5'd0, 5'd0, 5'd0, 0, 1, s, f);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 6'h00, 5'd1, 5'd2, 5'd3, 0, 1, s, f);
            cnt += int'(s);
        end
        check_eq("halt_drain_cycles", cnt, 3);
        check_eq("halt_set", halted, 1);
        for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 1), 6'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), $urandom_range(0, 1), 1, s, f);
        end
        check_eq("halt_sticky", halted, 1);

        // Reset during DRAIN returns to normal issue.
        nop_step(0);
        step(1, 6'h11, 5'd0, 5'd0, 5'd0, 0, 1, s, f);
        nop_step(1);
        step(1, 6'h00, 5'd1, 5'd2, 5'd3, 1, 0, s, f);
        check_eq("drain_rst_outputs", {s, f}, 2'b00);
        step(1, 6'h00, 5'd1, 5'd2, 5'd3, 0, 1, s, f);
        check_eq("drain_rst_issue", s, 0);
        check_eq("drain_rst_halted", halted, 0);

        // Randomized traffic on a small register window to provoke hazards
        // and counter saturation.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 15) == 0) ? 6'h3F : 6'($urandom_range(0, 19));
            if (op == 6'h11 && $urandom_range(0, 7) != 0) op = 6'h00;
            step($urandom_range(0, 9) != 0, op, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1), $urandom_range(0, 149) != 0, s, f);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core, sitting beside the ID stage. It decides every cycle whether the instruction held in IF/ID issues to EX, stalls on a register RAW hazard, waits out branch resolution, or drains the pipe on HALT. The core has no forwarding, so a 3-entry destination scoreboard models the EX/MEM/WB occupancy. Outputs drive the IF hold, the ID/EX bubble insert, the IF/ID flush and a sticky halt flag.

## Interface
- SB_DEPTH, 3: scoreboard entries, one each for EX, MEM and WB; fixed by pipeline depth.
- CNT_W, 16: width of the performance counters.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low.
- id_inst_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  6  opcode field inst[31:26].
- id_rs_addr / id_rt_addr / id_rd_addr  in  5 each  inst[25:21] / [20:16] / [15:11].
- ex_branch_taken  in  1  EX resolved the branch it holds as taken. Sampled only in BR_WAIT.
- stall_if  out  1  hold PC and IF/ID.
- bubble_id_ex  out  1  ID/EX loads an all-zero (NOP) bundle.
- flush_if_id  out  1  invalidate IF/ID at the next edge.
- halted  out  1  sticky; pipeline empty after HALT.
- stall_cnt / flush_cnt  out  CNT_W each  saturating counts of RAW-stall cycles and taken-branch flushes.

## Operation
- Source use by opcode:
  - rs and rt: R-type 0x00,02,04,06,08,0A; STW 0x0D; BEQ 0x0F.
  - rs only: I-type 0x01,03,05,07,09,0B; LDW 0x0C; BZ 0x0E; JR 0x10.
  - none: HALT 0x11 and undefined opcodes.
- Destination by opcode:
  - rd: R-type.
  - rt: I-type ALU and LDW.
  - none: all other opcodes.
  - Destination 0 is never recorded.
- Scoreboard:
  - Each entry is {valid, addr[4:0]}. Entries shift EX→MEM→WB every cycle.
  - Entry EX loads the dest of an issued instruction, else invalid.
- hazard = id_inst_valid AND a used source is nonzero AND it matches any valid entry.
- States: RUN, BR_WAIT, DRAIN, HALTED.
- RUN, first match in this order:
  - !id_inst_valid: bubble only.
  - hazard: stall_if=1, bubble=1, stall_cnt++.
  - else issue. Opcode 0x0E/0F/10 goes to BR_WAIT. HALT goes to DRAIN with drain counter = SB_DEPTH.
- BR_WAIT (exactly 1 cycle, branch is in EX): stall_if=1, bubble=1, flush_if_id=ex_branch_taken (then flush_cnt++). Returns to RUN. If not taken, the held instruction issues normally next cycle.
- DRAIN: stall_if=1, bubble=1, counter decrements. At 0 go to HALTED.
- HALTED: stall_if=1, bubble=1, halted=1 until reset. Inputs are ignored.
- Counters saturate at all-ones; they never wrap.
- Integration rule: IF gives a PC redirect priority over stall_if.

## Timing
- stall_if, bubble_id_ex and flush_if_id are combinational from state, scoreboard and ID inputs in the same cycle.
- State, scoreboard, drain counter, halted and counters update at posedge clk.
- Reset (reset=0 at a posedge):
  - state=RUN, scoreboard all invalid, counters 0, halted=0.
  - While reset=0, all combinational outputs are 0.
  - Reset mid-BR_WAIT or mid-DRAIN aborts to RUN with no residual flush.
- Back-to-back RAW dependency costs 3 stall cycles. The register file write at the WB edge is visible to the ID read in the following cycle.
- A dependency with 1 or 2 independent instructions between producer and consumer costs 2 or 1 stall cycles.
- Simultaneous hazard and HALT/branch opcode: hazard wins; the state transition happens only on issue.
- ex_branch_taken outside BR_WAIT has no effect.

## Structure
- Shared package (struct.sv):
  - opcode localparams;
  - state enum;
  - sb_entry_t struct;
  - function uses_rs/uses_rt/dest_of(opcode, rt, rd).
- Sub-module hazard_scoreboard: shift register plus match logic, with ports {issue, dest_valid, dest_addr, rs, rt, use_rs, use_rt} → hit.
- Top holds the FSM, drain counter and performance counters.

## Test plan
- add r3←r1,r2 followed by add r4←r3,r5: stall_if=1 for exactly 3 cycles, 3 bubbles, then issue; stall_cnt=3.
- addi r0 then a consumer of r0, and lw r7 then sw using r7 with 2 NOPs between: no stall for r0; 1 stall cycle for the r7 case.
- beq with ex_branch_taken=1: 1 cycle with stall/bubble/flush all 1; the following instruction is discarded; flush_cnt=1.
- bz with ex_branch_taken=0: 1 bubble; the held instruction issues next cycle; flush_cnt=0.
- HALT: 3 DRAIN cycles, then halted=1 and stays 1 for 100 cycles regardless of inputs.
- reset=0 asserted during DRAIN: the next cycle is RUN, halted=0, outputs 0; normal issue resumes after release.
